// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Optional feature macro: MEM_ARB_WRITE_PROTECT_EN (see mem_port_arbiter).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        COMPLETE
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin grant with a last-grant register.
// last_grant resets to the DMA port so the CPU wins the first tie.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    output logic       valid,
    output logic       winner
);

    logic last_grant;

    // Pick the requester; on a tie, the one not served last.
    always_comb begin
        valid  = |req;
        winner = PORT_CPU;
        unique case (1'b1)
            (req == 2'b11): winner = ~last_grant;
            (req == 2'b10): winner = PORT_DMA;
            default:        winner = PORT_CPU;
        endcase
    end

    // Remember who was granted when the owner commits the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_DMA;
        end else if (upd && valid) begin
            last_grant <= winner;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unclocked 8K x 8 memory between CPU (port 0) and DMA (port 1).
// Macro MEM_ARB_WRITE_PROTECT_EN blocks DMA writes below PROT_LIMIT.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int PROT_LIMIT = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              prot_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state;
    state_t state_nx;

    logic any_req;
    logic winner;
    logic grant_en;
    logic gnt_q;
    logic we_q;
    logic blk_q;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1, req0}),
        .upd    (grant_en),
        .valid  (any_req),
        .winner (winner)
    );

`ifdef MEM_ARB_WRITE_PROTECT_EN
    localparam logic [ADDR_W-1:0] PROT_A = ADDR_W'(PROT_LIMIT);

    logic blk_nx;

    assign blk_nx = (winner == PORT_DMA) && we1 && (addr1 < PROT_A);

    // Decide at grant time whether the DMA write must be suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q <= 1'b0;
        end else if (grant_en) begin
            blk_q <= blk_nx;
        end
    end
`else
    logic unused_prot;

    assign unused_prot = (PROT_LIMIT != 0);
    assign blk_q       = 1'b0;
`endif

    // State register; reset drops the strobes with no ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Sequencing and strobe/ack decode from the current state.
    always_comb begin
        state_nx  = state;
        grant_en  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        prot_err  = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    grant_en = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                state_nx = STROBE;
            end
            STROBE: begin
                mem_read  = ~we_q;
                mem_write = we_q & ~blk_q;
                state_nx  = COMPLETE;
            end
            COMPLETE: begin
                ack0     = (gnt_q == PORT_CPU);
                ack1     = (gnt_q == PORT_DMA);
                prot_err = blk_q;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Capture the winner's request so the memory sees stable values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q     <= PORT_CPU;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_en) begin
            gnt_q <= winner;
            if (winner == PORT_DMA) begin
                we_q      <= we1;
                mem_addr  <= addr1;
                mem_wdata <= wdata1;
            end else begin
                we_q      <= we0;
                mem_addr  <= addr0;
                mem_wdata <= wdata0;
            end
        end
    end

    // Latch read data while MemRead is high so it is valid with ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (state == STROBE && !we_q) begin
            if (gnt_q == PORT_DMA) begin
                rdata1 <= mem_rdata;
            end else begin
                rdata0 <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a level-sensitive memory model.
// Honours MEM_ARB_WRITE_PROTECT_EN for the protected-write expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [12:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        ack0, ack1, prot_err, busy;
    logic [7:0]  rdata0, rdata1;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    int rd_hi = 0;
    int wr_hi = 0;
    int ack0_n = 0;
    int ack1_n = 0;

    logic [7:0] mem [0:8191];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .rdata0    (rdata0),
        .ack1      (ack1),
        .rdata1    (rdata1),
        .prot_err  (prot_err),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;

    always @(posedge mem_write) begin
        mem[mem_addr] = mem_wdata;
        wr_pulses++;
    end

    always @(posedge mem_read) rd_pulses++;

    always @(negedge clk) begin
        if (mem_read) rd_hi++;
        if (mem_write) wr_hi++;
        if (ack0) ack0_n++;
        if (ack1) ack1_n++;
        checks++;
        if (mem_read && mem_write) begin
            errors++;
            $display("FAIL strobe_excl: both strobes high at %0t", $time);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic access(input bit p, input bit w,
                          input logic [12:0] a, input logic [7:0] d,
                          output int lat, output logic [7:0] rd,
                          output logic pe);
        @(negedge clk);
        if (p) begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end
        lat = 99;
        rd  = 8'h00;
        pe  = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (p ? ack1 : ack0) begin
                lat = i;
                rd  = p ? rdata1 : rdata0;
                pe  = prot_err;
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    typedef struct {
        bit         port;
        bit         we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vt [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int r0, w0, rh, wh, a0, a1, n, last_c;
        logic [7:0] rd;
        logic pe;
        bit prot_on;
        bit got;

`ifdef MEM_ARB_WRITE_PROTECT_EN
        prot_on = 1'b1;
`else
        prot_on = 1'b0;
`endif

        vt[0] = '{0, 0, 13'd1000, 8'h00, 8'd43};
        vt[1] = '{1, 1, 13'd2000, 8'hA5, 8'h00};
        vt[2] = '{0, 0, 13'd2000, 8'h00, 8'hA5};
        vt[3] = '{1, 0, 13'd2000, 8'h00, 8'hA5};
        vt[4] = '{0, 1, 13'd8191, 8'h3C, 8'hA5};
        vt[5] = '{1, 0, 13'd8191, 8'h00, 8'h3C};
        vt[6] = '{0, 1, 13'd0,    8'hFF, 8'hA5};
        vt[7] = '{1, 0, 13'd0,    8'h00, 8'hFF};

        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[1000] = 8'd43;
        mem[5]    = 8'h77;

        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {busy, mem_read, mem_write, ack0, ack1, prot_err},
            32'h0);
        chk("rst_bus", {mem_addr, mem_wdata}, 32'h0);
        chk("rst_rdata", {rdata0, rdata1}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", busy, 32'h0);

        for (int i = 0; i < 8; i++) begin
            r0 = rd_pulses; w0 = wr_pulses; rh = rd_hi; wh = wr_hi;
            access(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata,
                   lat, rd, pe);
            chk($sformatf("v%0d_lat", i), lat, 3);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("v%0d_rd_cycles", i), rd_hi - rh,
                vt[i].we ? 0 : 1);
            chk($sformatf("v%0d_wr_cycles", i), wr_hi - wh,
                vt[i].we ? 1 : 0);
            chk($sformatf("v%0d_pulses", i),
                (rd_pulses - r0) + (wr_pulses - w0), 1);
            if (vt[i].we)
                chk($sformatf("v%0d_mem", i), mem[vt[i].addr], vt[i].wdata);
            @(negedge clk);
            chk($sformatf("v%0d_idle", i), {busy, ack0, ack1}, 32'h0);
        end

        // Both ports hold requests: grants alternate, acks 4 cycles apart.
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 13'd1000;
        req1 = 1; we1 = 0; addr1 = 13'd2000;
        n = 0;
        last_c = 0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                chk($sformatf("tie%0d_both", n), ack0 & ack1, 0);
                chk($sformatf("tie%0d_port", n), ack1, n % 2);
                chk($sformatf("tie%0d_gap", n), c - last_c,
                    (n == 0) ? 3 : 4);
                chk($sformatf("tie%0d_rdata", n), ack1 ? rdata1 : rdata0,
                    ack1 ? 8'hA5 : 8'd43);
                last_c = c;
                n++;
            end
        end
        req0 = 0;
        req1 = 0;
        chk("tie_count", n, 4);
        @(negedge clk);

        // Reset in STROBE of a read after port 0 was granted last.
        access(0, 0, 13'd1000, 8'h00, lat, rd, pe);
        chk("pre_rst_lat", lat, 3);
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 13'd8191;
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("rst_strobe_on", mem_read, 1);
        a0 = ack0_n;
        a1 = ack1_n;
        rst_n = 1'b0;
        #1;
        chk("rst_strobe_drop", mem_read, 0);
        chk("rst_busy_drop", busy, 0);
        req0 = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_no_ack", (ack0_n - a0) + (ack1_n - a1), 0);
        chk("rst_rdata0", rdata0, 0);
        req0 = 1; we0 = 0; addr0 = 13'd1000;
        req1 = 1; we1 = 0; addr1 = 13'd2000;
        got = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                got = 1;
                chk("rst_tie_winner", {ack1, ack0}, 32'h1);
                chk("rst_tie_lat", c, 3);
                break;
            end
        end
        req0 = 0;
        req1 = 0;
        chk("rst_tie_seen", got, 1);
        repeat (5) @(negedge clk);

        // Request dropped during SETUP still completes once.
        req0 = 1; we0 = 0; addr0 = 13'd8191;
        @(negedge clk);
        req0 = 0;
        a0 = ack0_n;
        rd = 8'h00;
        repeat (6) begin
            @(negedge clk);
            if (ack0) rd = rdata0;
        end
        chk("drop_ack_count", ack0_n - a0, 1);
        chk("drop_rdata", rd, 8'h3C);

        // DMA write into the low (program) region.
        w0 = wr_pulses;
        access(1, 1, 13'd5, 8'h00, lat, rd, pe);
        chk("prot_lat", lat, 3);
        chk("prot_err", pe, prot_on);
        chk("prot_wr_pulses", wr_pulses - w0, prot_on ? 0 : 1);
        chk("prot_mem", mem[5], prot_on ? 8'h77 : 8'h00);
        @(negedge clk);
        chk("prot_err_pulse", prot_err, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
